pac_mover: RTL

PAC_MOVER -- requirements
Module: pac_mover

---
 rtl/pac_pkg.sv | 24 ++
 rtl/pac_mover_if.sv | 13 +
 rtl/pac_mover_ps2_dir_decode.sv | 32 +++
 rtl/pac_mover.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// pac_pkg: shared direction/state encodings, scan codes and position stepping for the Pac-Man movers and display
package pac_pkg;

    typedef enum logic [1:0] {DIR_R = 2'd0, DIR_L = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_t;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, BLOCKED = 2'd2} state_t;

    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // Returns {x, y} as two 11-bit values; a step below zero wraps to a huge
    // value, so it always falls outside any play box and reads as blocked.
    function automatic logic [21:0] step_pos(input logic [9:0] x, input logic [9:0] y,
                                             input dir_t d, input logic [9:0] s);
        logic [10:0] xe, ye, se;
        xe = {1'b0, x};
        ye = {1'b0, y};
        se = {1'b0, s};
        return {d == DIR_R ? xe + se : d == DIR_L ? xe - se : xe,
                d == DIR_D ? ye + se : d == DIR_U ? ye - se : ye};
    endfunction

endpackage

// File: rtl/pac_mover_if.sv
// pac_mover_if: keyboard word input and wall-map query bus of the Pac-Man mover
//   ps2_data/ps2_ready : keyboard word and its level-style valid
//   wall_hit           : wall-map answer for (chk_x, chk_y), same cycle
//   chk_x/chk_y        : candidate position presented to the wall map
interface pac_mover_if;
    logic [9:0] ps2_data;
    logic       ps2_ready;
    logic       wall_hit;
    logic [9:0] chk_x;
    logic [9:0] chk_y;
    modport master (output ps2_data, ps2_ready, wall_hit, input chk_x, chk_y);
    modport slave  (input ps2_data, ps2_ready, wall_hit, output chk_x, chk_y);
endinterface

// File: rtl/pac_mover_ps2_dir_decode.sv
// ps2_dir_decode: turns a rising edge of ps2_ready into a direction strobe for extended arrow make codes
//   clk, rst       : clock, asynchronous active-high reset
//   ps2_data       : [9] E0-extended, [8] break, [7:0] scan code
//   ps2_ready      : level; each 0->1 transition carries a new word
//   req_dir        : decoded direction, meaningful while req_strobe is high
//   req_strobe     : one-cycle pulse for a recognised arrow make code
module ps2_dir_decode
    import pac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ps2_data,
    input  logic       ps2_ready,
    output dir_t       req_dir,
    output logic       req_strobe
);
    logic ready_q;
    logic known;

    always_ff @(posedge clk or posedge rst)
        if (rst) ready_q <= 1'b0;
        else     ready_q <= ps2_ready;

    always_comb begin
        req_dir    = ps2_data[7:0] == SC_RIGHT ? DIR_R :
                     ps2_data[7:0] == SC_LEFT  ? DIR_L :
                     ps2_data[7:0] == SC_UP    ? DIR_U : DIR_D;
        known      = ps2_data[7:0] inside {SC_RIGHT, SC_LEFT, SC_UP, SC_DOWN};
        // only extended make codes steer; break codes and plain keys are dropped
        req_strobe = ps2_ready & ~ready_q & ps2_data[9] & ~ps2_data[8] & known;
    end
endmodule

// File: rtl/pac_mover.sv
// pac_mover: keyboard-steered Pac-Man position register with wall and play-box blocking
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : keyboard word in, wall-map query out (see pac_mover_if)
//   PacX/PacY   : registered position
//   dir         : facing direction (0 right, 1 left, 2 up, 3 down)
//   anim        : mouth frame, advances on each tick while moving
//   moving      : high in state MOVE
module pac_mover
    import pac_pkg::*;
#(
    parameter logic [9:0]  INIT_X   = 10'd320,
    parameter logic [9:0]  INIT_Y   = 10'd240,
    parameter logic [9:0]  X_MIN    = 10'd16,
    parameter logic [9:0]  X_MAX    = 10'd623,
    parameter logic [9:0]  Y_MIN    = 10'd16,
    parameter logic [9:0]  Y_MAX    = 10'd463,
    parameter logic [9:0]  STEP     = 10'd2,
    parameter logic [21:0] TICK_DIV = 22'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    pac_mover_if.slave  bus,
    output logic [9:0]  PacX,
    output logic [9:0]  PacY,
    output dir_t        dir,
    output logic [1:0]  anim,
    output logic        moving
);
    state_t      state, state_n;
    logic [21:0] cnt;
    logic        tick;
    logic        rv, rv_n, key_strobe;
    dir_t        rd, rd_n, key_dir, dir_n, cand_d;
    logic [9:0]  x_n, y_n;
    logic [1:0]  anim_n;
    logic [21:0] cand, fall;
    logic        cand_free, fall_free;

    function automatic logic in_box(input logic [10:0] x, input logic [10:0] y);
        return x >= {1'b0, X_MIN} && x <= {1'b0, X_MAX} && y >= {1'b0, Y_MIN} && y <= {1'b0, Y_MAX};
    endfunction

    ps2_dir_decode u_dec (
        .clk       (clk),
        .rst       (rst),
        .ps2_data  (bus.ps2_data),
        .ps2_ready (bus.ps2_ready),
        .req_dir   (key_dir),
        .req_strobe(key_strobe)
    );

    assign tick      = cnt == TICK_DIV - 22'd1;
    assign cand_d    = rv ? rd : dir;
    assign cand      = step_pos(PacX, PacY, cand_d, STEP);
    assign fall      = step_pos(PacX, PacY, dir, STEP);
    assign bus.chk_x = cand[20:11];
    assign bus.chk_y = cand[9:0];
    assign cand_free = in_box(cand[21:11], cand[10:0]) && !bus.wall_hit;
    // the wall map answers only the requested turn, so carrying straight on
    // while a turn waits is judged against the play box alone
    assign fall_free = in_box(fall[21:11], fall[10:0]);
    assign moving    = state == MOVE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            PacX  <= INIT_X;
            PacY  <= INIT_Y;
            dir   <= DIR_R;
            anim  <= '0;
            rv    <= 1'b0;
            rd    <= DIR_R;
        end else begin
            state <= state_n;
            cnt   <= tick ? '0 : cnt + 22'd1;
            PacX  <= x_n;
            PacY  <= y_n;
            dir   <= dir_n;
            anim  <= anim_n;
            rv    <= rv_n;
            rd    <= rd_n;
        end

    always_comb begin
        state_n = state;
        x_n     = PacX;
        y_n     = PacY;
        dir_n   = dir;
        anim_n  = anim;
        rv_n    = rv;
        rd_n    = rd;
        case (state)
            IDLE:
                if (rv) begin
                    state_n = MOVE;
                    dir_n   = rd;
                    rv_n    = 1'b0;
                end
            MOVE:
                if (tick) begin
                    anim_n = anim + 2'd1;
                    if (cand_free) begin
                        x_n   = cand[20:11];
                        y_n   = cand[9:0];
                        dir_n = cand_d;
                        rv_n  = 1'b0;
                    end else if (rv && fall_free) begin
                        x_n = fall[20:11];
                        y_n = fall[9:0];
                    end else begin
                        state_n = BLOCKED;
                    end
                end
            BLOCKED:
                if (tick && rv && cand_free) begin
                    state_n = MOVE;
                    x_n     = cand[20:11];
                    y_n     = cand[9:0];
                    dir_n   = rd;
                    rv_n    = 1'b0;
                end
            default: state_n = IDLE;
        endcase
        // a key landing on a tick cycle is queued after the tick has used the old request
        if (key_strobe) begin
            rv_n = 1'b1;
            rd_n = key_dir;
        end
    end
endmodule
